// File: rtl/led_mode_sequencer_if.sv
// led_mode_sequencer_if: raw switch pins in, LED pins and mode/pause status out.
interface led_mode_sequencer_if;
  logic [3:0] i_sw_n;
  logic       o_led_blue;
  logic       o_led_green;
  logic       o_led_orange;
  logic       o_led_red;
  logic [1:0] o_mode;
  logic       o_paused;
  modport master (output i_sw_n, input o_led_blue, o_led_green, o_led_orange, o_led_red, o_mode, o_paused);
  modport slave  (input i_sw_n, output o_led_blue, o_led_green, o_led_orange, o_led_red, o_mode, o_paused);
endinterface

// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer: debounced push switches step four LEDs through OFF/CHASE/BLINK/BINARY modes.
// Define LED_ACTIVE_LOW_EN to drive the LED pins inverted for active-low boards.
module led_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int TICK_CYCLES     = 3000000
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  led_mode_sequencer_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TICK_CYCLES);
  typedef enum logic [1:0] {OFF, CHASE, BLINK, BINARY} mode_t;
  logic [3:0] s1, s2, db, db_d, blk, ev, p, p_step, p_entry;
  logic [1:0] live;
  logic [DW-1:0] dcnt [4];
  logic [TW-1:0] tcnt, tmax;
  mode_t mode, mode_nx;
  logic paused, fast, mc, tick, tclr;
  // blk masks switches seen pressed during reset until a genuine release is observed
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      s1   <= '1;
      s2   <= '1;
      db_d <= '1;
      live <= '0;
      blk  <= ~bus.i_sw_n;
    end else begin
      s1   <= bus.i_sw_n;
      s2   <= s1;
      db_d <= db;
      live <= {live[0], 1'b1};
      blk  <= blk & ~(db & s2 & {4{live[1]}});
    end
  always_ff @(posedge i_clk)
    for (int i = 0; i < 4; i++)
      if (!i_rst_n) begin
        dcnt[i] <= '0;
        db[i]   <= 1'b1;
      end else if (s2[i] == db[i]) begin
        dcnt[i] <= '0;
      end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        dcnt[i] <= '0;
        db[i]   <= s2[i];
      end else begin
        dcnt[i] <= dcnt[i] + DW'(1);
      end
  assign ev      = db_d & ~db & ~blk;
  assign mc      = ev[0] ^ ev[1];
  assign mode_nx = mode_t'(ev[0] ? mode + 2'd1 : mode - 2'd1);
  assign tmax    = fast ? TW'(TICK_CYCLES / 2 - 1) : TW'(TICK_CYCLES - 1);
  assign tick    = !paused && tcnt == tmax;
  assign tclr    = mc || ev[3] || (ev[2] && !paused);
  assign p_entry = mode_nx == CHASE ? 4'b0001 : mode_nx == BLINK ? 4'b1111 : 4'b0000;
  assign p_step  = mode == CHASE ? {p[2:0], p[3]} : mode == BLINK ? ~p : mode == BINARY ? p + 4'd1 : 4'b0000;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      mode   <= OFF;
      p      <= '0;
      paused <= 1'b0;
      fast   <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (mc) begin
        mode <= mode_nx;
        p    <= p_entry;
      end else if (tick) begin
        p <= p_step;
      end
      paused <= paused ^ ev[2];
      fast   <= fast ^ ev[3];
      tcnt   <= (tclr || tick) ? '0 : paused ? tcnt : tcnt + TW'(1);
    end
`ifdef LED_ACTIVE_LOW_EN
  assign {bus.o_led_blue, bus.o_led_green, bus.o_led_orange, bus.o_led_red} = ~p;
`else
  assign {bus.o_led_blue, bus.o_led_green, bus.o_led_orange, bus.o_led_red} = p;
`endif
  assign bus.o_mode   = mode;
  assign bus.o_paused = paused;
endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer: directed plus random switch stimulus; an edge-timed model feeds a scoreboard of output changes.
module tb_led_mode_sequencer;
  localparam int DEB = 4;
  localparam int TCK = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  led_mode_sequencer_if bus ();
  led_mode_sequencer #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TCK)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  typedef struct {
    int         c;
    logic [6:0] v;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit go = 1'b0;
  function automatic logic [3:0] lv(int p);
`ifdef LED_ACTIVE_LOW_EN
    return ~4'(p);
`else
    return 4'(p);
`endif
  endfunction
  function automatic logic [3:0] led_val();
    return {bus.o_led_blue, bus.o_led_green, bus.o_led_orange, bus.o_led_red};
  endfunction
  function automatic logic [6:0] obs();
    return {bus.o_mode, bus.o_paused, led_val()};
  endfunction
  function automatic int entry(int m);
    return m == 1 ? 1 : m == 2 ? 15 : 0;
  endfunction
  function automatic int step_p(int m, int p);
    return m == 1 ? ((p << 1) | (p >> 3)) & 15 : m == 2 ? 15 - p : m == 3 ? (p + 1) % 16 : 0;
  endfunction
  task automatic chk(string n, int got, int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, got, expv);
    end
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(logic [3:0] m, int lo = 8, int hi = 8);
    bus.i_sw_n = ~m;
    idle(lo);
    bus.i_sw_n = '1;
    idle(hi);
  endtask
  // reference model: switch history, debounced states and an absolute-cycle tick schedule
  logic [3:0] raw, d1, d2, sv, mdb, mblk, pend, ev;
  bit dv1, dv2, svld, tick, mpaused, mfast;
  int run[4];
  int mmode, mp, due;
  logic [6:0] prevv, v;
  initial begin
    d1 = '1; d2 = '1; dv1 = 0; dv2 = 0; mdb = '1; mblk = '0; pend = '0;
    mmode = 0; mp = 0; mpaused = 0; mfast = 0; due = TCK;
    for (int i = 0; i < 4; i++) run[i] = 0;
    prevv = {2'b00, 1'b0, lv(0)};
    forever begin
      @(posedge clk);
      cyc++;
      raw = bus.i_sw_n;
      if (!rst_n) begin
        d1 = '1; d2 = '1; dv1 = 0; dv2 = 0; mdb = '1; mblk = ~raw; pend = '0;
        for (int i = 0; i < 4; i++) run[i] = 0;
        mmode = 0; mp = 0; mpaused = 0; mfast = 0; due = cyc + TCK;
      end else begin
        sv = d2; svld = dv2; d2 = d1; dv2 = dv1; d1 = raw; dv1 = 1'b1;
        ev = pend;
        pend = '0;
        for (int i = 0; i < 4; i++) begin
          if (svld && sv[i] && mdb[i]) mblk[i] = 1'b0;
          if (sv[i] == mdb[i]) run[i] = 0;
          else begin
            run[i]++;
            if (run[i] == DEB) begin
              mdb[i] = sv[i];
              run[i] = 0;
              pend[i] = !sv[i] && !mblk[i];
            end
          end
        end
        tick = !mpaused && cyc == due;
        if (ev[0] != ev[1]) begin
          mmode = ev[0] ? (mmode + 1) % 4 : (mmode + 3) % 4;
          mp = entry(mmode);
        end else if (tick) mp = step_p(mmode, mp);
        if (tick) due = cyc + (mfast ? TCK / 2 : TCK);
        mfast ^= ev[3];
        mpaused ^= ev[2];
        if (ev[0] != ev[1] || ev[3] || ev[2]) due = cyc + (mfast ? TCK / 2 : TCK);
      end
      v = {2'(mmode), mpaused, lv(mp)};
      if (v !== prevv) q.push_back('{cyc, v});
      prevv = v;
    end
  end
  logic [6:0] o, last;
  exp_t e;
  initial begin
    wait (go);
    last = obs();
    forever begin
      @(negedge clk);
      o = obs();
      if (o !== last) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change cycle %0d: got %b, required no change", cyc, o);
        end else begin
          e = q.pop_front();
          total++;
          if (e.v !== o) begin
            bad++;
            $display("FAIL output_value cycle %0d: got %b required %b", cyc, o, e.v);
          end
          total++;
          if (e.c != cyc) begin
            bad++;
            $display("FAIL output_timing: change at cycle %0d required at cycle %0d", cyc, e.c);
          end
        end
      end
      last = o;
    end
  end
  initial begin
    int k;
    bus.i_sw_n = '1;
    idle(3);
    chk("reset_mode", bus.o_mode, 0);
    chk("reset_paused", bus.o_paused, 0);
    chk("reset_leds", led_val(), lv(0));
    go = 1'b1;
    rst_n = 1'b1;
    idle(4);
    rst_n = 1'b0;
    bus.i_sw_n = 4'b1110;
    idle(4);
    rst_n = 1'b1;
    idle(20);
    chk("held_through_reset", bus.o_mode, 0);
    bus.i_sw_n = '1;
    idle(12);
    press(4'b0001);
    chk("repress_after_reset", bus.o_mode, 1);
    press(4'b0010);
    chk("back_to_off", bus.o_mode, 0);
    bus.i_sw_n = 4'b1110;
    idle(2);
    bus.i_sw_n = '1;
    idle(10);
    chk("glitch_ignored", bus.o_mode, 0);
    bus.i_sw_n = 4'b1110;
    idle(6);
    chk("press_latency_early", bus.o_mode, 0);
    idle(1);
    chk("press_latency_mode", bus.o_mode, 1);
    chk("chase_entry", led_val(), lv(1));
    idle(1);
    bus.i_sw_n = '1;
    idle(40);
    press(4'b0010);
    press(4'b0010);
    chk("wrap_down", bus.o_mode, 3);
    idle(132);
    press(4'b0010);
    chk("blink_mode", bus.o_mode, 2);
    idle(20);
    press(4'b1000);
    idle(20);
    press(4'b1000);
    idle(20);
    press(4'b0010);
    idle(10);
    press(4'b0100);
    chk("paused_on", bus.o_paused, 1);
    idle(40);
    press(4'b0001);
    chk("mode_while_paused", bus.o_mode, 2);
    chk("blink_entry_paused", led_val(), lv(15));
    idle(20);
    press(4'b0100);
    chk("paused_off", bus.o_paused, 0);
    idle(20);
    press(4'b0011);
    chk("both_pressed", bus.o_mode, 2);
    k = 0;
    while (due - cyc != 7 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("tick_align_found", k < 40, 1);
    bus.i_sw_n = 4'b1110;
    idle(7);
    chk("mode_on_tick", bus.o_mode, 3);
    chk("entry_beats_tick", led_val(), lv(0));
    idle(1);
    bus.i_sw_n = '1;
    idle(30);
    repeat (30) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.i_sw_n = 4'($urandom_range(0, 15));
        rst_n = 1'b0;
        idle($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      bus.i_sw_n = ~4'($urandom_range(0, 15));
      idle($urandom_range(1, 10));
      bus.i_sw_n = '1;
      idle($urandom_range(1, 12));
    end
    idle(30);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_changes: got %0d unconsumed, required 0", q.size());
    end
    total++;
    if (obs() !== prevv) begin
      bad++;
      $display("FAIL final_state: got %b required %b", obs(), prevv);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
